alu_control_seq: RTL and testbench

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_control_seq.sv | 136 +++++++++++++
 tb/tb_alu_control_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_seq.sv
// ALU control decoder with a valid/ready handshake on both sides.
// Single-cycle ops return one cycle after acceptance; MULT/DIV take MC_CYCLES.
module alu_control_seq #(
  parameter int FUNC_W    = 6,
  parameter int OP_W      = 4,
  parameter int MC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              inValid,
  output logic              inReady,
  input  logic [1:0]        aluInstruct,
  input  logic [FUNC_W-1:0] instructFunc,
  output logic              outValid,
  input  logic              outReady,
  output logic [OP_W-1:0]   aluOperationCode,
  output logic              illegal,
  output logic              multiCycle,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_e;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MULT = OP_W'(5);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(6);

  localparam logic [FUNC_W-1:0] F_ADD  = FUNC_W'(6'b100000);
  localparam logic [FUNC_W-1:0] F_SUB  = FUNC_W'(6'b100010);
  localparam logic [FUNC_W-1:0] F_AND  = FUNC_W'(6'b100100);
  localparam logic [FUNC_W-1:0] F_OR   = FUNC_W'(6'b100101);
  localparam logic [FUNC_W-1:0] F_SLT  = FUNC_W'(6'b101010);
  localparam logic [FUNC_W-1:0] F_MULT = FUNC_W'(6'b011000);
  localparam logic [FUNC_W-1:0] F_DIV  = FUNC_W'(6'b011010);

  localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            ill_q, ill_d;
  logic            mc_q, mc_d;

  logic [OP_W-1:0] dec_op;
  logic            dec_ill, dec_mc, accept;

  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    dec_mc  = 1'b0;
    case (aluInstruct)
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (instructFunc)
          F_ADD:   dec_op = OP_ADD;
          F_SUB:   dec_op = OP_SUB;
          F_AND:   dec_op = OP_AND;
          F_OR:    dec_op = OP_OR;
          F_SLT:   dec_op = OP_SLT;
          F_MULT:  begin dec_op = OP_MULT; dec_mc = 1'b1; end
          F_DIV:   begin dec_op = OP_DIV;  dec_mc = 1'b1; end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_op = OP_ADD;
    endcase
  end

  // Ready never looks at inValid, so drain and refill can share a cycle.
  assign inReady = rstN && ((state_q == IDLE) || ((state_q == HOLD) && outReady));
  assign accept  = inValid && inReady;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    mc_d    = mc_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          op_d  = dec_op;
          ill_d = dec_ill;
          mc_d  = dec_mc;
          if (dec_mc) begin
            state_d = COUNT;
            cnt_d   = MC_LOAD;
          end else begin
            state_d = HOLD;
          end
        end else if (state_q == HOLD && outReady) begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (cnt_q <= 8'd1) begin
          state_d = HOLD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d   = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      mc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      mc_q    <= mc_d;
    end
  end

  assign outValid         = (state_q == HOLD);
  assign busy             = (state_q == COUNT);
  assign aluOperationCode = op_q;
  assign illegal          = ill_q;
  assign multiCycle       = mc_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: timing checks inline, results via a scoreboard.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       rstN;
  logic       inValid, inReady;
  logic [1:0] aluInstruct;
  logic [5:0] instructFunc;
  logic       outValid, outReady;
  logic [3:0] aluOperationCode;
  logic       illegal, multiCycle, busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] op;
    logic       ill;
    logic       mc;
  } exp_t;

  exp_t sb[$];

  alu_control_seq #(.FUNC_W(6), .OP_W(4), .MC_CYCLES(4)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .aluInstruct(aluInstruct), .instructFunc(instructFunc),
    .outValid(outValid), .outReady(outReady),
    .aluOperationCode(aluOperationCode), .illegal(illegal),
    .multiCycle(multiCycle), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] ai, input logic [5:0] f);
    exp_t e;
    e = '{op: 4'd0, ill: 1'b0, mc: 1'b0};
    if (ai == 2'b01) e.op = 4'd1;
    else if (ai == 2'b10) begin
      case (f)
        6'b100000: e.op = 4'd0;
        6'b100010: e.op = 4'd1;
        6'b100100: e.op = 4'd2;
        6'b100101: e.op = 4'd3;
        6'b101010: e.op = 4'd4;
        6'b011000: begin e.op = 4'd5; e.mc = 1'b1; end
        6'b011010: begin e.op = 4'd6; e.mc = 1'b1; end
        default:   e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rstN) begin
      if (outValid && outReady) begin
        if (sb.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_op", 32'(aluOperationCode), 32'(e.op));
          chk("sb_illegal", 32'(illegal), 32'(e.ill));
          chk("sb_multicycle", 32'(multiCycle), 32'(e.mc));
        end
      end
      if (inValid && inReady) sb.push_back(model(aluInstruct, instructFunc));
    end
  end

  always @(negedge rstN) sb.delete();

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
    aluInstruct = 2'b00; instructFunc = 6'd0;
    #2;
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op", 32'(aluOperationCode), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_mc", 32'(multiCycle), 32'd0);
    #10 rstN = 1'b1;
    #1 chk("post_rst_inReady", 32'(inReady), 32'd1);
    tick();

    // ADD then SUB back-to-back
    inValid = 1'b1; aluInstruct = 2'b10; instructFunc = 6'b100000;
    tick();
    chk("add_valid", 32'(outValid), 32'd1);
    chk("add_op", 32'(aluOperationCode), 32'd0);
    chk("add_inReady", 32'(inReady), 32'd1);
    instructFunc = 6'b100010;
    tick();
    chk("sub_valid", 32'(outValid), 32'd1);
    chk("sub_op", 32'(aluOperationCode), 32'd1);
    chk("sub_inReady", 32'(inReady), 32'd1);
    inValid = 1'b0;
    tick();
    chk("drain_idle", 32'(outValid), 32'd0);

    // MULT latency
    inValid = 1'b1; instructFunc = 6'b011000;
    tick();
    inValid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("mult_busy", 32'(busy), 32'd1);
      chk("mult_inReady", 32'(inReady), 32'd0);
      chk("mult_novalid", 32'(outValid), 32'd0);
      tick();
    end
    chk("mult_valid", 32'(outValid), 32'd1);
    chk("mult_op", 32'(aluOperationCode), 32'd5);
    chk("mult_mc", 32'(multiCycle), 32'd1);
    chk("mult_busy_done", 32'(busy), 32'd0);
    tick();

    // Backpressure on AND, OR accepted in the drain cycle
    inValid = 1'b1; instructFunc = 6'b100100; outReady = 1'b0;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(outValid), 32'd1);
      chk("bp_op", 32'(aluOperationCode), 32'd2);
      chk("bp_inReady", 32'(inReady), 32'd0);
      tick();
    end
    outReady = 1'b1; inValid = 1'b1; instructFunc = 6'b100101;
    #1;
    chk("bp_drain_op", 32'(aluOperationCode), 32'd2);
    chk("bp_drain_inReady", 32'(inReady), 32'd1);
    tick();
    inValid = 1'b0;
    chk("or_valid", 32'(outValid), 32'd1);
    chk("or_op", 32'(aluOperationCode), 32'd3);
    tick();

    // Illegal function field, then SLT
    inValid = 1'b1; instructFunc = 6'b111111;
    tick();
    chk("ill_valid", 32'(outValid), 32'd1);
    chk("ill_op", 32'(aluOperationCode), 32'd0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_mc", 32'(multiCycle), 32'd0);
    instructFunc = 6'b101010;
    tick();
    inValid = 1'b0;
    chk("slt_op", 32'(aluOperationCode), 32'd4);
    chk("slt_flag", 32'(illegal), 32'd0);
    tick();

    // Reset during DIV count
    inValid = 1'b1; instructFunc = 6'b011010;
    tick();
    inValid = 1'b0;
    tick();
    #2 rstN = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(outValid), 32'd0);
    chk("midrst_inReady", 32'(inReady), 32'd0);
    chk("midrst_op", 32'(aluOperationCode), 32'd0);
    chk("midrst_mc", 32'(multiCycle), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 chk("midrst_release_inReady", 32'(inReady), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_no_result", 32'(outValid), 32'd0);
    end

    // Non-R-type classes with random function fields
    inValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] ai;
      logic [3:0] eop;
      ai  = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
      eop = (k == 1) ? 4'd1 : 4'd0;
      aluInstruct = ai; instructFunc = 6'($urandom);
      tick();
      chk("sweep_valid", 32'(outValid), 32'd1);
      chk("sweep_op", 32'(aluOperationCode), 32'(eop));
      chk("sweep_illegal", 32'(illegal), 32'd0);
    end
    inValid = 1'b0;
    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
